// File: rtl/display_pkg.sv
// Shared types and constants for the display scan / BCD front end.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } disp_state_e;

  localparam int          DIGITS   = 4;
  localparam int          NIBBLE_W = 4;
  localparam logic [15:0] DEC_MAX  = 16'd9999;
  localparam logic [15:0] DEC_SAT  = 16'h9999;

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[k*NIBBLE_W +: NIBBLE_W] >= 4'd5)
        r[k*NIBBLE_W +: NIBBLE_W] = v[k*NIBBLE_W +: NIBBLE_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter, one shift-add-3 step per cycle.
module bin16_to_bcd_seq
  import display_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [15:0] sh_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [4:0]  iter_q;
  logic        busy_q;

  assign bcd_adj = add3_nibbles(bcd_q);

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sh_q   <= bin;
      bcd_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q  <= {bcd_adj[14:0], sh_q[15]};
      sh_q   <= {sh_q[14:0], 1'b0};
      iter_q <= iter_q + 5'd1;
      if (iter_q == 5'd15)
        busy_q <= 1'b0;
    end
  end

  // done is high in the cycle whose edge performs the 16th iteration,
  // so bcd is final on the following cycle.
  assign busy = busy_q;
  assign done = busy_q && (iter_q == 5'd15);
  assign bcd  = bcd_q;

endmodule

// File: rtl/display_scan_bcd.sv
// Display front end: per-frame snapshot, optional BCD conversion, and
// time-multiplexed digit scan with leading-zero blanking.
//
// state  | meaning
// IDLE   | waiting for a frame start, display register stable
// SHIFT  | BCD engine running 16 shift-add-3 iterations
// COMMIT | write display register and ovf, back to IDLE
module display_scan_bcd
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        dec_mode,
  output logic [3:0]  digit_select,
  output logic [3:0]  digit_nibble,
  output logic        ovf
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  disp_state_e      state_q, state_nxt;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       idx_q, idx_nxt;
  logic             scan_on_q, scan_on_nxt;
  logic             start_pending_q;
  logic             go_q;
  logic [15:0]      snap_q;
  logic             mode_q;
  logic [15:0]      disp_q, disp_nxt;
  logic             ovf_q, ovf_nxt;
  logic [3:0]       sel_q, sel_nxt;
  logic [3:0]       nib_q, nib_nxt;
  logic             tick;
  logic             frame_start;
  logic             eng_start, eng_busy, eng_done;
  logic [15:0]      eng_bcd;
  logic [3:0]       lead_zero;
  logic             digit_on;

  bin16_to_bcd_seq u_bcd (
    .clk_i (clk_i),
    .reset (reset),
    .start (eng_start),
    .bin   (snap_q),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  // The first tick only switches scanning on at digit 0; later ticks advance.
  assign tick        = (refresh_cnt == CNT_LAST);
  assign scan_on_nxt = scan_on_q | tick;
  assign idx_nxt     = (tick && scan_on_q) ? idx_q + 2'd1 : idx_q;
  assign frame_start = start_pending_q | (tick & scan_on_q & (idx_q == 2'd3));

  always_comb begin
    state_nxt = state_q;
    eng_start = 1'b0;
    disp_nxt  = disp_q;
    ovf_nxt   = ovf_q;
    case (state_q)
      IDLE: begin
        if (go_q && !eng_busy) begin
          if (mode_q) begin
            state_nxt = SHIFT;
            eng_start = 1'b1;
          end else begin
            state_nxt = COMMIT;
          end
        end
      end
      SHIFT: begin
        if (eng_done)
          state_nxt = COMMIT;
      end
      COMMIT: begin
        if (!mode_q) begin
          disp_nxt = snap_q;
          ovf_nxt  = 1'b0;
        end else if (snap_q > DEC_MAX) begin
          disp_nxt = DEC_SAT;
          ovf_nxt  = 1'b1;
        end else begin
          disp_nxt = eng_bcd;
          ovf_nxt  = 1'b0;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle values so they track the slot edge.
  always_comb begin
    lead_zero[3] = (disp_nxt[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_nxt[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_nxt[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    digit_on     = scan_on_nxt && !(BLANK_LEADING && lead_zero[idx_nxt]);
    sel_nxt      = digit_on ? ~(4'b0001 << idx_nxt) : 4'b1111;
    nib_nxt      = disp_nxt[idx_nxt*NIBBLE_W +: NIBBLE_W];
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      refresh_cnt     <= '0;
      idx_q           <= '0;
      scan_on_q       <= 1'b0;
      start_pending_q <= 1'b1;
      go_q            <= 1'b0;
      snap_q          <= '0;
      mode_q          <= 1'b0;
      disp_q          <= '0;
      ovf_q           <= 1'b0;
      sel_q           <= 4'b1111;
      nib_q           <= '0;
    end else begin
      refresh_cnt     <= tick ? '0 : refresh_cnt + CNT_W'(1);
      idx_q           <= idx_nxt;
      scan_on_q       <= scan_on_nxt;
      start_pending_q <= 1'b0;
      go_q            <= frame_start;
      if (frame_start) begin
        snap_q <= count;
        mode_q <= dec_mode;
      end
      disp_q <= disp_nxt;
      ovf_q  <= ovf_nxt;
      sel_q  <= sel_nxt;
      nib_q  <= nib_nxt;
    end
  end

  assign digit_select = sel_q;
  assign digit_nibble = nib_q;
  assign ovf          = ovf_q;

endmodule
